// File: rtl/rnn_mem_pkg.sv
// Shared constants, memory select encodings and index helpers for the RNN memory slice.
package rnn_mem_pkg;

  localparam int unsigned AW = 17;
  localparam int unsigned DW = 20;
  localparam int unsigned SW = 3;

  typedef enum logic [2:0] {
    MSEL_XW  = 3'b000,
    MSEL_B1  = 3'b001,
    MSEL_HW  = 3'b010,
    MSEL_B2  = 3'b011,
    MSEL_CNT = 3'b100,
    MSEL_OUT = 3'b101
  } msel_e;

  // Successor of a requester index in a ring of n requesters.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/rnn_rr_picker.sv
// Rotating-priority encoder: first asserted request scanning upward from rr_ptr, wrapping.
module rnn_rr_picker #(
  parameter int unsigned N  = 3,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] rr_ptr,
  output logic [IW-1:0] pick,
  output logic          pick_vld
);

  int unsigned idx;

  // Scan N positions starting at rr_ptr; the first hit wins.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = 0;
    for (int unsigned off = 0; off < N; off++) begin
      idx = (32'(rr_ptr) + off) % N;
      if (!pick_vld && req[IW'(idx)]) begin
        pick     = IW'(idx);
        pick_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rnn_mem_arbiter.sv
// Round-robin arbiter sharing the single RNN memory port, with burst locking, a forced-release
// bound and fixed-latency read-data routing back to the issuing requester.
module rnn_mem_arbiter #(
  parameter int unsigned NREQ      = 3,
  parameter int unsigned AW        = 17,
  parameter int unsigned DW        = 20,
  parameter int unsigned SW        = 3,
  parameter int unsigned MAX_BURST = 64,
  parameter int unsigned RD_LAT    = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    wr,
  input  logic [NREQ-1:0]    last,
  input  logic [NREQ*SW-1:0] sel,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    rvalid,
  output logic [DW-1:0]      rdata,
  output logic               busy,
  output logic               mce,
  output logic [SW-1:0]      msel,
  output logic [AW-1:0]      maddr,
  output logic [DW-1:0]      mdata_w,
  input  logic [DW-1:0]      mdata_r
);

  import rnn_mem_pkg::*;

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned BW = $clog2(MAX_BURST + 1);

  logic              owner_vld;
  logic [IW-1:0]     owner_idx;
  logic [IW-1:0]     rr_ptr;
  logic [BW-1:0]     burst_cnt;
  // Read-ness and requester of the command currently on the memory pins.
  logic              cmd_rd;
  logic [IW-1:0]     cmd_idx;
  // Read tags travelling alongside the memory's read latency.
  logic [RD_LAT-1:0] tag_vld;
  logic [IW-1:0]     tag_idx [RD_LAT];

  logic [IW-1:0]     pick;
  logic              pick_vld;
  logic              beat;
  logic [IW-1:0]     beat_idx;
  logic              burst_end;
  logic [IW-1:0]     rr_inc;

  rnn_rr_picker #(
    .N  (NREQ),
    .IW (IW)
  ) u_picker (
    .req      (req),
    .rr_ptr   (rr_ptr),
    .pick     (pick),
    .pick_vld (pick_vld)
  );

  // Grant: the owner keeps the port while it requests; otherwise the round-robin pick.
  always_comb begin
    beat_idx  = owner_vld ? owner_idx : pick;
    beat      = 1'b0;
    if (!reset) begin
      beat = owner_vld ? req[owner_idx] : pick_vld;
    end
    gnt       = beat ? (NREQ'(1) << beat_idx) : '0;
    burst_end = (32'(burst_cnt) == MAX_BURST - 1);
    rr_inc    = IW'(rr_next(32'(beat_idx), NREQ));
  end

  // Ownership, pointer, burst counter and the registered memory command.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_vld <= 1'b0;
      owner_idx <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
      mce       <= 1'b0;
      msel      <= SW'(MSEL_XW);
      maddr     <= '0;
      mdata_w   <= '0;
      cmd_rd    <= 1'b0;
      cmd_idx   <= '0;
    end else if (beat) begin
      mce     <= 1'b1;
      msel    <= sel[beat_idx*SW +: SW];
      maddr   <= addr[beat_idx*AW +: AW];
      mdata_w <= wdata[beat_idx*DW +: DW];
      cmd_rd  <= ~wr[beat_idx];
      cmd_idx <= beat_idx;
      if (last[beat_idx] || burst_end) begin
        owner_vld <= 1'b0;
        burst_cnt <= '0;
        rr_ptr    <= rr_inc;
      end else begin
        owner_vld <= 1'b1;
        owner_idx <= beat_idx;
        burst_cnt <= burst_cnt + BW'(1);
      end
    end else begin
      mce    <= 1'b0;
      cmd_rd <= 1'b0;
      // Owner stopped requesting: drop it and move the pointer past it.
      if (owner_vld) begin
        owner_vld <= 1'b0;
        burst_cnt <= '0;
        rr_ptr    <= rr_inc;
      end
    end
  end

  // Shift read tags so the last stage lines up with valid mdata_r.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_vld <= '0;
      for (int i = 0; i < RD_LAT; i++) tag_idx[i] <= '0;
    end else begin
      tag_vld[0] <= mce & cmd_rd;
      tag_idx[0] <= cmd_idx;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_idx[i] <= tag_idx[i-1];
      end
    end
  end

  // Read return routing and activity flag, both silenced during reset.
  always_comb begin
    rvalid = '0;
    if (!reset && tag_vld[RD_LAT-1]) rvalid = NREQ'(1) << tag_idx[RD_LAT-1];
    rdata  = mdata_r;
    busy   = !reset && (owner_vld || mce || (|tag_vld));
  end

endmodule

// File: doc/rnn_mem_arbiter.md
Name: rnn_mem_arbiter

Overview:
- Shares the single RNN memory port (mce/msel/maddr/mdata_w/mdata_r) among NREQ requesters, e.g. RNN compute core, result writeback, host readback/debug.
- Round-robin arbitration with burst locking and a forced-release bound.
- Issues registered memory commands and routes read data back to the issuing requester after a fixed read latency.
- Sits between the requesters and the memory macro.

Parameters:
NREQ, 3, number of requesters
AW, 17, address width
DW, 20, data width
SW, 3, msel width
MAX_BURST, 64, max beats per ownership before forced release (>=1)
RD_LAT, 1, cycles from command on the memory pins to valid mdata_r (>=1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
req  in  NREQ  per-requester access request
wr  in  NREQ  1 = write beat (no read return)
last  in  NREQ  beat ends the burst
sel  in  NREQ*SW  per-requester msel, packed, requester i at [i*SW +: SW]
addr  in  NREQ*AW  per-requester address, packed
wdata  in  NREQ*DW  per-requester write data, packed
gnt  out  NREQ  one-hot; beat accepted this cycle
rvalid  out  NREQ  one-hot; read data for requester i valid
rdata  out  DW  read data, equal to mdata_r
busy  out  1  owner held, command on the pins, or read in flight
mce  out  1  memory chip enable
msel  out  SW  memory select
maddr  out  AW  memory address
mdata_w  out  DW  memory write data
mdata_r  in  DW  memory read data

Behaviour:
- State: owner_vld, owner_idx, rr_ptr, burst_cnt, read-tag pipeline of RD_LAT stages (valid + index).
- Reset values: mce=0, msel=0, maddr=0, mdata_w=0, owner_vld=0, rr_ptr=0, burst_cnt=0, pipeline cleared.
- Reset forces outputs: gnt=0, rvalid=0, busy=0.
- gnt is combinational from registered state and req.
- IDLE (owner_vld=0):
  - pick = first i with req[i], scanning rr_ptr, rr_ptr+1, ... mod NREQ.
  - gnt[pick]=1. With no req, gnt=0.
- LOCKED (owner_vld=1):
  - gnt[owner_idx]=req[owner_idx]; all others 0.
  - If req[owner_idx]=0, release at the edge with no beat: owner_vld<=0, rr_ptr<=owner_idx+1.
- Accepted beat (gnt[k]=1), at the edge:
  - mce<=1; msel/maddr/mdata_w <= sel/addr/wdata of k.
  - burst_cnt<=burst_cnt+1.
  - If wr[k]=0, the tag for k enters the read pipeline.
- Release on an accepted beat when last[k]=1 or burst_cnt==MAX_BURST-1:
  - owner_vld<=0, burst_cnt<=0, rr_ptr<=(k+1) mod NREQ.
  - Otherwise owner_vld<=1, owner_idx<=k.
- Back-to-back single-beat requests from different requesters issue every cycle with no bubble.
- No beat accepted: mce<=0; msel/maddr/mdata_w hold their values.
- Read return: a command on the pins in cycle T gives rvalid[k]=1 in cycle T+RD_LAT, with rdata=mdata_r (passthrough). Writes never raise rvalid. No backpressure on rvalid.
- MAX_BURST=1 degenerates to per-beat round-robin.
- Fairness: a continuously requesting requester waits at most (NREQ-1)*MAX_BURST accepted beats, plus one cycle per dropped owner.
- Simultaneous release and new requests: the release edge updates rr_ptr, and the next cycle arbitrates with the new rr_ptr.
- Reset mid-burst or with reads in flight:
  - Ownership is dropped and pending read tags are discarded.
  - No rvalid after reset, even if the memory still returns data.
- busy = owner_vld | mce | any pipeline valid.

Decomposition:
- Package rnn_mem_pkg:
  - AW, DW, SW constants.
  - msel encodings: MSEL_XW=3'b000, MSEL_B1=3'b001, MSEL_HW=3'b010, MSEL_B2=3'b011, MSEL_CNT=3'b100, MSEL_OUT=3'b101.
- Sub-module rnn_rr_picker: combinational rotating-priority encoder (req, rr_ptr -> pick, pick_vld), reusable by other arbiters.

Test Plan:
- Single read, RD_LAT=1:
  - Stimulus: req[0] with sel=000, addr=0x00005, last=1, memory returns 0x12345.
  - Response: gnt[0] in cycle 0; mce=1 and maddr=5 in cycle 1; rvalid[0]=1 and rdata=0x12345 in cycle 2; busy falls in cycle 3.
- Round-robin:
  - Stimulus: req=3'b111 held, all last=1, after reset.
  - Response: grant order 0,1,2,0,1,2, with no idle cycles on mce.
- Burst lock:
  - Stimulus: req[1] for 4 beats (last on the 4th), req[0] held meanwhile.
  - Response: gnt[1] for 4 consecutive cycles, then gnt[0]; maddr follows requester 1's addresses.
- Forced release:
  - Stimulus: MAX_BURST=4; req[2] with last=0 forever; req[0] asserted.
  - Response: requester 2 gets 4 beats, then requester 0 gets one beat, then requester 2 resumes.
- Write vs read:
  - Stimulus: requester 1 writes sel=101, addr=0x00840, wdata=0xF0000.
  - Response: mdata_w=0xF0000, msel=101, mce=1 for one cycle; rvalid stays 0.
- Reset mid-flight:
  - Stimulus: RD_LAT=2; assert reset one cycle after a read command appears on the pins.
  - Response: rvalid=0 throughout, mce=0, busy=0, and grant restarts at requester 0.
